// File: rtl/regfile_pkg.sv
// ============================================================================
// Module   : regfile_pkg
// Brief    : Default parameters and write-port arbitration helper for regfile_mp_bypass.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_NUM_WR   = 1;
    localparam int DEF_BYPASS   = 1;
    localparam int DEF_R0_ZERO  = 1;
    localparam int MAX_WR_PORTS = 32;

    // Highest-indexed set bit wins a same-register write conflict.
    function automatic int win_port(input logic [MAX_WR_PORTS-1:0] hits);
        int w;
        w = 0;
        for (int k = 0; k < MAX_WR_PORTS; k++) begin
            if (hits[k]) begin
                w = k;
            end
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Per-register pending bits with flush/write/reserve priority and read lookup.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int NUM_WR   = DEF_NUM_WR,
    parameter int R0_ZERO  = DEF_R0_ZERO,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD-1:0][AW-1:0]    rd_sel_i,
    input  logic [NUM_RD-1:0]            rd_byp_i,
    input  logic [NUM_WR-1:0]            wr_en_i,
    input  logic [NUM_WR-1:0][AW-1:0]    wr_sel_i,
    input  logic                         rsv_en_i,
    input  logic [AW-1:0]                rsv_sel_i,
    input  logic                         flush_i,
    output logic [NUM_RD-1:0]            rd_pend_o
);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;
    logic                rsv_ok;

    assign rsv_ok = rsv_en_i && !((R0_ZERO != 0) && (rsv_sel_i == '0));

    // Reserve is applied last so a new producer outranks a retiring write or a flush.
    always_comb begin
        pend_d = pend_q;
        if (flush_i) begin
            pend_d = '0;
        end
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en_i[k]) begin
                pend_d[wr_sel_i[k]] = 1'b0;
            end
        end
        if (rsv_ok) begin
            pend_d[rsv_sel_i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_pend
        assign rd_pend_o[i] = pend_q[rd_sel_i[i]] && !rd_byp_i[i]
                              && !((R0_ZERO != 0) && (rd_sel_i[i] == '0));
    end

endmodule

`default_nettype wire

// File: rtl/regfile_mp_bypass.sv
// ============================================================================
// Module   : regfile_mp_bypass
// Brief    : Multi-port register file with write-to-read bypass and pending scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp_bypass
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int NUM_WR   = DEF_NUM_WR,
    parameter int BYPASS   = DEF_BYPASS,
    parameter int R0_ZERO  = DEF_R0_ZERO,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_RD-1:0][AW-1:0]       rd_sel_i,
    output logic [NUM_RD-1:0][DATA_W-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]               rd_pend_o,
    input  logic [NUM_WR-1:0]               wr_en_i,
    input  logic [NUM_WR-1:0][AW-1:0]       wr_sel_i,
    input  logic [NUM_WR-1:0][DATA_W-1:0]   wr_data_i,
    input  logic                            rsv_en_i,
    input  logic [AW-1:0]                   rsv_sel_i,
    input  logic                            flush_i
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [NUM_WR-1:0] wr_en_eff;
    logic [NUM_RD-1:0] rd_byp;

    for (genvar k = 0; k < NUM_WR; k++) begin : g_wr_en
        assign wr_en_eff[k] = wr_en_i[k] && !((R0_ZERO != 0) && (wr_sel_i[k] == '0));
    end

    // Ascending port order lets the highest-indexed writer land last.
    always_comb begin
        regs_d = regs_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en_eff[k]) begin
                regs_d[wr_sel_i[k]] = wr_data_i[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [MAX_WR_PORTS-1:0] hit_ext;
        logic [DATA_W-1:0]       byp_data;
        int                      win;

        always_comb begin
            hit_ext = '0;
            for (int k = 0; k < NUM_WR; k++) begin
                hit_ext[k] = wr_en_eff[k] && (wr_sel_i[k] == rd_sel_i[i]);
            end
            win      = win_port(hit_ext);
            byp_data = '0;
            for (int k = 0; k < NUM_WR; k++) begin
                if (k == win) begin
                    byp_data = wr_data_i[k];
                end
            end
        end

        assign rd_byp[i] = (BYPASS != 0) && (|hit_ext);

        assign rd_data_o[i] = ((R0_ZERO != 0) && (rd_sel_i[i] == '0)) ? '0 :
                              rd_byp[i]                               ? byp_data :
                                                                        regs_q[rd_sel_i[i]];
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .R0_ZERO  (R0_ZERO)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .rd_sel_i  (rd_sel_i),
        .rd_byp_i  (rd_byp),
        .wr_en_i   (wr_en_eff),
        .wr_sel_i  (wr_sel_i),
        .rsv_en_i  (rsv_en_i),
        .rsv_sel_i (rsv_sel_i),
        .flush_i   (flush_i),
        .rd_pend_o (rd_pend_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp_bypass.sv
// ============================================================================
// Module   : tb_regfile_mp_bypass
// Brief    : Scoreboard bench for a bypassing 2-write instance and a non-bypassing 1-write instance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp_bypass;

    logic                  clk;
    logic                  rst;
    logic [1:0][4:0]       rd_sel;
    logic [1:0]            wr_en;
    logic [1:0][4:0]       wr_sel;
    logic [1:0][31:0]      wr_data;
    logic                  rsv_en;
    logic [4:0]            rsv_sel;
    logic                  flush;

    logic [1:0][31:0]      m_data;
    logic [1:0]            m_pend;
    logic [1:0][31:0]      n_data;
    logic [1:0]            n_pend;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        int          dut;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        p0;
        logic        p1;
    } exp_t;

    exp_t exp_q[$];

    regfile_mp_bypass #(
        .DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1), .R0_ZERO(1)
    ) u_main (
        .clk       (clk),
        .rst       (rst),
        .rd_sel_i  (rd_sel),
        .rd_data_o (m_data),
        .rd_pend_o (m_pend),
        .wr_en_i   (wr_en),
        .wr_sel_i  (wr_sel),
        .wr_data_i (wr_data),
        .rsv_en_i  (rsv_en),
        .rsv_sel_i (rsv_sel),
        .flush_i   (flush)
    );

    regfile_mp_bypass #(
        .DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(1), .BYPASS(0), .R0_ZERO(1)
    ) u_nobyp (
        .clk       (clk),
        .rst       (rst),
        .rd_sel_i  (rd_sel),
        .rd_data_o (n_data),
        .rd_pend_o (n_pend),
        .wr_en_i   (wr_en[0:0]),
        .wr_sel_i  (wr_sel[0:0]),
        .wr_data_i (wr_data[0:0]),
        .rsv_en_i  (rsv_en),
        .rsv_sel_i (rsv_sel),
        .flush_i   (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so every queued expectation is
    // consumed on the falling edge of the cycle it was issued in.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [1:0][31:0] d;
            logic [1:0]       p;
            e = exp_q.pop_front();
            d = (e.dut == 0) ? m_data : n_data;
            p = (e.dut == 0) ? m_pend : n_pend;
            chk({e.name, ".data0"}, d[0], e.d0);
            chk({e.name, ".data1"}, d[1], e.d1);
            chk({e.name, ".pend0"}, {31'b0, p[0]}, {31'b0, e.p0});
            chk({e.name, ".pend1"}, {31'b0, p[1]}, {31'b0, e.p1});
        end
    end

    task automatic expect_rd(input string nm, input int dut, input logic [31:0] d0,
                             input logic [31:0] d1, input logic p0, input logic p1);
        exp_t e;
        e.name = nm;
        e.dut  = dut;
        e.d0   = d0;
        e.d1   = d1;
        e.p0   = p0;
        e.p1   = p1;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        wr_en   = 2'b00;
        wr_sel  = '0;
        wr_data = '0;
        rsv_en  = 1'b0;
        rsv_sel = '0;
        flush   = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int a, input int b);
        rd_sel[0] = a[4:0];
        rd_sel[1] = b[4:0];
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rd(0, 0);
        step();
        step();
        rst = 1'b0;

        // Reset contents on both ports of the main instance
        for (int r = 0; r < 32; r++) begin
            rd(r, 31 - r);
            expect_rd($sformatf("reset_r%0d", r), 0, 32'h0, 32'h0, 1'b0, 1'b0);
            step();
        end

        // Same-cycle bypass vs. registered read
        idle();
        rd(5, 6);
        wr_en[0] = 1'b1; wr_sel[0] = 5'd5; wr_data[0] = 32'hDEADBEEF;
        expect_rd("byp_wr5", 0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        expect_rd("nobyp_wr5", 1, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        idle();
        expect_rd("byp_rd5", 0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        expect_rd("nobyp_rd5", 1, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        step();

        // Two ports write r7: port 1 wins
        rd(7, 5);
        wr_en = 2'b11;
        wr_sel[0] = 5'd7; wr_data[0] = 32'h1111;
        wr_sel[1] = 5'd7; wr_data[1] = 32'h2222;
        expect_rd("conflict_byp", 0, 32'h2222, 32'hDEADBEEF, 1'b0, 1'b0);
        step();
        idle();
        expect_rd("conflict_store", 0, 32'h2222, 32'hDEADBEEF, 1'b0, 1'b0);
        step();

        // r0 ignores writes and reservations
        rd(0, 0);
        wr_en[0] = 1'b1; wr_sel[0] = 5'd0; wr_data[0] = 32'hFFFF;
        rsv_en = 1'b1; rsv_sel = 5'd0;
        expect_rd("r0_wr", 0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        idle();
        expect_rd("r0_after", 0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();

        // Reserve r3, then write clears with bypass
        rd(3, 0);
        rsv_en = 1'b1; rsv_sel = 5'd3;
        expect_rd("rsv3_same", 0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        idle();
        expect_rd("rsv3_next", 0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        wr_en[0] = 1'b1; wr_sel[0] = 5'd3; wr_data[0] = 32'h55;
        expect_rd("wr3_byp", 0, 32'h55, 32'h0, 1'b0, 1'b0);
        expect_rd("wr3_nobyp", 1, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        idle();
        expect_rd("wr3_after", 0, 32'h55, 32'h0, 1'b0, 1'b0);
        expect_rd("wr3_after_nb", 1, 32'h55, 32'h0, 1'b0, 1'b0);
        step();

        // Write and reserve same register: pend ends set
        wr_en[0] = 1'b1; wr_sel[0] = 5'd3; wr_data[0] = 32'h66;
        rsv_en = 1'b1; rsv_sel = 5'd3;
        expect_rd("wrrsv3_same", 0, 32'h66, 32'h0, 1'b0, 1'b0);
        step();
        idle();
        expect_rd("wrrsv3_next", 0, 32'h66, 32'h0, 1'b1, 1'b0);
        step();

        // Flush with concurrent reserve
        rd(4, 9);
        rsv_en = 1'b1; rsv_sel = 5'd4;
        step();
        rsv_sel = 5'd9;
        step();
        idle();
        expect_rd("rsv4_9", 0, 32'h0, 32'h0, 1'b1, 1'b1);
        flush = 1'b1; rsv_en = 1'b1; rsv_sel = 5'd9;
        step();
        idle();
        expect_rd("flush_4_9", 0, 32'h0, 32'h0, 1'b0, 1'b1);
        step();
        rd(3, 9);
        expect_rd("flush_3", 0, 32'h66, 32'h0, 1'b0, 1'b1);
        step();

        // Reset mid-stream overrides write and reserve
        rst = 1'b1;
        rsv_en = 1'b1; rsv_sel = 5'd10;
        wr_en[0] = 1'b1; wr_sel[0] = 5'd12; wr_data[0] = 32'hABCD;
        step();
        rst = 1'b0;
        idle();
        rd(12, 9);
        expect_rd("rst_12_9", 0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        rd(5, 10);
        expect_rd("rst_5_10", 0, 32'h0, 32'h0, 1'b0, 1'b0);
        expect_rd("rst_5_10_nb", 1, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        rd(7, 3);
        expect_rd("rst_7_3", 0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();

        for (int t = 0; t < 10 && exp_q.size() > 0; t++) begin
            step();
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
